// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// The rotate feature is selected by the SHIFTER_ROTATE_EN macro in shift_stage.
package shifter_pkg;

  typedef enum logic [2:0] {
    SLL = 3'd0,
    SRL = 3'd1,
    SRA = 3'd2,
    ROL = 3'd3,
    ROR = 3'd4
  } shift_op_t;

  // Lowest amount bit handled by stage k when nb amount bits are spread over
  // the given number of stages. The first (nb % stages) stages take one extra
  // bit, so groups are ceil-balanced and low stages own the low-order bits.
  // grp_lo(k+1) - 1 is the highest bit of stage k.
  function automatic int grp_lo(input int k, input int nb, input int stages);
    int base;
    int rem;
    base = nb / stages;
    rem  = nb % stages;
    return k * base + ((k < rem) ? k : rem);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One registered stage of the pipelined shifter. It shifts by the amount bits
// BIT_HI..BIT_LO only and forwards op and the full amount to the next stage.
// Macro SHIFTER_ROTATE_EN: when defined ROL/ROR rotate; otherwise they
// behave as SLL/SRL and no rotate logic is built.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int BIT_LO    = 0,
  parameter int BIT_HI    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  shift_op_t                    in_op,
  input  logic [$clog2(DATAWIDTH)-1:0] in_n,
  input  logic [DATAWIDTH-1:0]         in_d,
  output logic                         out_valid,
  input  logic                         out_ready,
  output shift_op_t                    out_op,
  output logic [$clog2(DATAWIDTH)-1:0] out_n,
  output logic [DATAWIDTH-1:0]         out_d
);

  localparam int NW = $clog2(DATAWIDTH);

  logic [NW-1:0]        amt;
  logic [DATAWIDTH-1:0] shifted;
`ifdef SHIFTER_ROTATE_EN
  logic [2*DATAWIDTH-1:0] dbl;
`endif

  logic                 load;
  logic                 valid_d, valid_q;
  shift_op_t            op_d, op_q;
  logic [NW-1:0]        n_d, n_q;
  logic [DATAWIDTH-1:0] d_d, d_q;

  // Partial shift: keep only this stage's amount bits, in place.
  always_comb begin
    amt                = '0;
    amt[BIT_HI:BIT_LO] = in_n[BIT_HI:BIT_LO];
    shifted            = in_d;
`ifdef SHIFTER_ROTATE_EN
    dbl                = '0;
`endif
    case (in_op)
      SLL: shifted = in_d << amt;
      SRL: shifted = in_d >> amt;
      SRA: shifted = $signed(in_d) >>> amt;
`ifdef SHIFTER_ROTATE_EN
      ROL: begin
        dbl     = {in_d, in_d} << amt;
        shifted = dbl[2*DATAWIDTH-1:DATAWIDTH];
      end
      ROR: begin
        dbl     = {in_d, in_d} >> amt;
        shifted = dbl[DATAWIDTH-1:0];
      end
`else
      ROL: shifted = in_d << amt;
      ROR: shifted = in_d >> amt;
`endif
      default: shifted = in_d;
    endcase
  end

  // Load when empty or when the next stage takes our beat this cycle.
  always_comb begin
    load    = !valid_q || out_ready;
    valid_d = valid_q;
    op_d    = op_q;
    n_d     = n_q;
    d_d     = d_q;
    if (load) begin
      valid_d = in_valid;
      if (in_valid) begin
        op_d = in_op;
        n_d  = in_n;
        d_d  = shifted;
      end
    end
  end

  // Stage register; reset clears valid and data alike.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= SLL;
      n_q     <= '0;
      d_q     <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      n_q     <= n_d;
      d_q     <= d_d;
    end
  end

  assign in_ready  = load;
  assign out_valid = valid_q;
  assign out_op    = op_q;
  assign out_n     = n_q;
  assign out_d     = d_q;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter with per-stage valid/ready handshake.
// Amount bits are split across STAGES shift_stage instances.
// Macro SHIFTER_ROTATE_EN enables real rotates for ROL/ROR.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int STAGES    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  shift_op_t                    in_op,
  input  logic [$clog2(DATAWIDTH)-1:0] in_n,
  input  logic [DATAWIDTH-1:0]         in_d,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATAWIDTH-1:0]         out_d
);

  localparam int NW = $clog2(DATAWIDTH);

  logic [STAGES:0]      v_s;
  logic [STAGES:0]      r_s;
  shift_op_t            op_s [STAGES+1];
  logic [NW-1:0]        n_s  [STAGES+1];
  logic [DATAWIDTH-1:0] d_s  [STAGES+1];

  assign v_s[0]      = in_valid;
  assign op_s[0]     = in_op;
  assign n_s[0]      = in_n;
  assign d_s[0]      = in_d;
  assign in_ready    = r_s[0];
  assign r_s[STAGES] = out_ready;
  assign out_valid   = v_s[STAGES];
  assign out_d       = d_s[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = grp_lo(k, NW, STAGES);
    localparam int HI = grp_lo(k + 1, NW, STAGES) - 1;

    shift_stage #(
      .DATAWIDTH(DATAWIDTH),
      .BIT_LO   (LO),
      .BIT_HI   (HI)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_valid (v_s[k]),
      .in_ready (r_s[k]),
      .in_op    (op_s[k]),
      .in_n     (n_s[k]),
      .in_d     (d_s[k]),
      .out_valid(v_s[k+1]),
      .out_ready(r_s[k+1]),
      .out_op   (op_s[k+1]),
      .out_n    (n_s[k+1]),
      .out_d    (d_s[k+1])
    );
  end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter (DATAWIDTH=8, STAGES=3).
// Expected results follow SHIFTER_ROTATE_EN if it is defined for the build.
module tb_pipelined_shifter;
  import shifter_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  shift_op_t  in_op;
  logic [2:0] in_n;
  logic [7:0] in_d;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_d;

  pipelined_shifter #(.DATAWIDTH(8), .STAGES(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_n     (in_n),
    .in_d     (in_d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_d    (out_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SHIFTER_ROTATE_EN
  localparam logic [7:0] ROL_A5_7 = 8'hD2;
  localparam logic [7:0] ROR_A5_1 = 8'hD2;
  localparam bit         ROT      = 1'b1;
`else
  localparam logic [7:0] ROL_A5_7 = 8'h80;
  localparam logic [7:0] ROR_A5_1 = 8'h52;
  localparam bit         ROT      = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-serial reference model.
  function automatic logic [7:0] model(input logic [2:0] op, input logic [2:0] n,
                                       input logic [7:0] d);
    logic [7:0] r;
    r = d;
    for (int i = 0; i < int'(n); i++) begin
      case (op)
        3'd0: r = {r[6:0], 1'b0};
        3'd1: r = {1'b0, r[7:1]};
        3'd2: r = {r[7], r[7:1]};
        3'd3: r = ROT ? {r[6:0], r[7]} : {r[6:0], 1'b0};
        3'd4: r = ROT ? {r[0], r[7:1]} : {1'b0, r[7:1]};
        default: r = r;
      endcase
    end
    return r;
  endfunction

  // Scoreboard: driver publishes the expectation of the beat it offers.
  logic [7:0] drv_exp;
  logic [7:0] sb_q[$];
  logic       prev_stall;
  logic [7:0] prev_d;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", {24'd0, out_d}, {24'd0, prev_d});
      end
      if (in_valid && in_ready) sb_q.push_back(drv_exp);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_beat", {24'd0, out_d}, 32'hFFFF_FFFF);
        end else begin
          chk("sb_data", {24'd0, out_d}, {24'd0, sb_q.pop_front()});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_d;
    end
  end

  typedef struct {
    logic [2:0] op;
    logic [2:0] n;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic drive(input logic [2:0] op, input logic [2:0] n, input logic [7:0] d,
                       input logic [7:0] exp);
    in_valid = 1'b1;
    in_op    = shift_op_t'(op);
    in_n     = n;
    in_d     = d;
    drv_exp  = exp;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(name, sb_q.size(), 0);
  endtask

  // One beat on an idle pipe; cycles counted from the accepting edge.
  task automatic lat_test(input string name, input logic [2:0] op, input logic [2:0] n,
                          input logic [7:0] d, input logic [7:0] exp);
    int k;
    @(posedge clk); #1;
    drive(op, n, d, exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 1;
    while (k < 10) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      k++;
    end
    chk({name, "_latency"}, k, 3);
    chk({name, "_data"}, {24'd0, out_d}, {24'd0, exp});
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] bp_d [4];
    int         acc_cnt;
    int         sent;
    int         guard;
    bit         acc;
    logic [2:0] rop;
    logic [2:0] rn;
    logic [7:0] rd;

    rst       = 1'b1;
    out_ready = 1'b1;
    drive(3'd0, 3'd1, 8'hFF, 8'h00);

    // Reset state, with a beat offered that must be ignored.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_d", {24'd0, out_d}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
    end

    // SRA latency.
    lat_test("sra", 3'd2, 3'd3, 8'h90, 8'hF2);

    // Table-driven vectors, streamed back to back.
    tbl.push_back('{3'd2, 3'd3, 8'h90, 8'hF2});
    tbl.push_back('{3'd3, 3'd7, 8'hA5, ROL_A5_7});
    tbl.push_back('{3'd4, 3'd1, 8'hA5, ROR_A5_1});
    tbl.push_back('{3'd0, 3'd0, 8'h5A, 8'h5A});
    tbl.push_back('{3'd1, 3'd0, 8'h5A, 8'h5A});
    tbl.push_back('{3'd2, 3'd0, 8'h5A, 8'h5A});
    tbl.push_back('{3'd3, 3'd0, 8'h5A, 8'h5A});
    tbl.push_back('{3'd4, 3'd0, 8'h5A, 8'h5A});
    tbl.push_back('{3'd6, 3'd4, 8'h5A, 8'h5A});
    tbl.push_back('{3'd5, 3'd7, 8'h3C, 8'h3C});
    tbl.push_back('{3'd0, 3'd7, 8'hFF, 8'h80});
    tbl.push_back('{3'd0, 3'd7, 8'hFE, 8'h00});
    tbl.push_back('{3'd2, 3'd7, 8'h80, 8'hFF});
    tbl.push_back('{3'd2, 3'd7, 8'h7F, 8'h00});
    tbl.push_back('{3'd1, 3'd7, 8'h80, 8'h01});
    tbl.push_back('{3'd1, 3'd5, 8'hF0, 8'h07});
    tbl.push_back('{3'd0, 3'd5, 8'h0F, 8'hE0});
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].op, tbl[i].n, tbl[i].d, tbl[i].exp);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain("tbl_drain");

    // Back-to-back SLL: results on consecutive cycles.
    for (int i = 1; i <= 3; i++) begin
      drive(3'd0, 3'(i), 8'h01, 8'h01 << i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_first_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_0", {24'd0, out_d}, 32'h02);
    @(negedge clk);
    chk("b2b_1", {24'd0, out_d}, 32'h04);
    @(negedge clk);
    chk("b2b_2", {24'd0, out_d}, 32'h08);
    drain("b2b_drain");

    // Backpressure: 5 stalled cycles with 4 beats offered.
    bp_d[0] = 8'h11; bp_d[1] = 8'h22; bp_d[2] = 8'h44; bp_d[3] = 8'h81;
    acc_cnt = 0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (acc_cnt < 4) drive(3'd1, 3'd1, bp_d[acc_cnt], bp_d[acc_cnt] >> 1);
      else in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) chk("bp_hold_first", {24'd0, out_d}, 32'h08);
      if (in_valid && in_ready) acc_cnt++;
    end
    chk("bp_accepted", acc_cnt, 3);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    guard = 0;
    while (acc_cnt < 4 && guard < 20) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      drive(3'd1, 3'd1, bp_d[acc_cnt], bp_d[acc_cnt] >> 1);
      @(negedge clk);
      if (in_valid && in_ready) acc_cnt++;
      guard++;
    end
    chk("bp_all_accepted", acc_cnt, 4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("bp_drain");

    // Reset with two beats in flight.
    drive(3'd0, 3'd1, 8'h03, 8'h06);
    @(posedge clk); #1;
    drive(3'd0, 3'd2, 8'h03, 8'h0C);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_d", {24'd0, out_d}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_stale", {31'd0, out_valid}, 32'd0);
    end
    lat_test("after_rst", 3'd0, 3'd4, 8'h0B, 8'hB0);

    // Random stream with random backpressure.
    sent  = 0;
    guard = 0;
    acc   = 1'b0;
    in_valid = 1'b0;
    while (sent < 200 && guard < 3000) begin
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        rop = 3'($urandom_range(0, 7));
        rn  = 3'($urandom_range(0, 7));
        rd  = 8'($urandom_range(0, 255));
        drive(rop, rn, rd, model(rop, rn, rd));
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sent++;
      guard++;
    end
    chk("rand_sent", sent, 200);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
